arb_req_ctrl: RTL and testbench

Request-side controller that sits directly upstream of the two-client grant arbiter. Each client queues transactions by pulsing `push_N`. The block turns each queued transaction into a held `req_N` toward the arbiter, counts `BURST_LEN` granted beats, and then releases the request for one cycle so the arbiter can re-arbitrate. Both client channels are identical and independent; they share only the clock and reset.

---
 rtl/arb_req_ctrl.sv | 133 +++++++++++++
 tb/tb_arb_req_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/arb_req_ctrl.sv
// Two-client request controller: each channel turns queued pushes into held
// requests toward the arbiter, counts BURST_LEN granted beats, then releases for one cycle.
module arb_req_chan #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             gnt,
    output logic             req,
    output logic             beat,
    output logic             done,
    output logic [CNT_W-1:0] pend,
    output logic             ovf
);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0]    BCNT_MAX = BW'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;

    state_t          state, state_nxt;
    logic [BW-1:0]   bcnt, bcnt_nxt;
    logic            last;

    always_comb begin
        state_nxt = state;
        bcnt_nxt  = bcnt;
        beat      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: if (pend != '0) state_nxt = REQ;
            REQ, XFER: begin
                if (gnt) begin
                    beat = 1'b1;
                    // BURST_LEN=1 folds into this compare since BCNT_MAX is then 0
                    if (bcnt == BCNT_MAX) begin
                        last      = 1'b1;
                        state_nxt = REL;
                        bcnt_nxt  = '0;
                    end else begin
                        bcnt_nxt  = bcnt + BW'(1);
                        state_nxt = XFER;
                    end
                end else if (state == XFER) begin
                    state_nxt = REQ;
                end
            end
            REL:     state_nxt = (pend != '0) ? REQ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            bcnt  <= '0;
            req   <= 1'b0;
            done  <= 1'b0;
            pend  <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            bcnt  <= bcnt_nxt;
            req   <= (state_nxt == REQ) || (state_nxt == XFER);
            done  <= last;
            // push and completion together cancel; a lone push at saturation is dropped
            case ({push, last})
                2'b10: begin
                    if (pend == PEND_MAX) ovf  <= 1'b1;
                    else                  pend <= pend + CNT_W'(1);
                end
                2'b01:   pend <= pend - CNT_W'(1);
                default: ;
            endcase
        end
    end
endmodule

module arb_req_ctrl #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_0,
    input  logic             push_1,
    input  logic             gnt_0,
    input  logic             gnt_1,
    output logic             req_0,
    output logic             req_1,
    output logic             beat_0,
    output logic             beat_1,
    output logic             done_0,
    output logic             done_1,
    output logic [CNT_W-1:0] pend_0,
    output logic [CNT_W-1:0] pend_1,
    output logic             ovf_0,
    output logic             ovf_1
);
    localparam int NUM_CH = 2;

    logic [NUM_CH-1:0]            push_v, gnt_v, req_v, beat_v, done_v, ovf_v;
    logic [NUM_CH-1:0][CNT_W-1:0] pend_v;

    assign push_v = {push_1, push_0};
    assign gnt_v  = {gnt_1, gnt_0};

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            arb_req_chan #(.BURST_LEN(BURST_LEN), .CNT_W(CNT_W)) u_chan (
                .clock (clock),
                .reset (reset),
                .push  (push_v[g]),
                .gnt   (gnt_v[g]),
                .req   (req_v[g]),
                .beat  (beat_v[g]),
                .done  (done_v[g]),
                .pend  (pend_v[g]),
                .ovf   (ovf_v[g])
            );
        end
    endgenerate

    assign {req_1,  req_0}  = req_v;
    assign {beat_1, beat_0} = beat_v;
    assign {done_1, done_0} = done_v;
    assign {ovf_1,  ovf_0}  = ovf_v;
    assign pend_0 = pend_v[0];
    assign pend_1 = pend_v[1];
endmodule

// File: tb/tb_arb_req_ctrl.sv
// Directed bench for arb_req_ctrl (BURST_LEN=4, CNT_W=3) with hand-computed expectations.
module tb_arb_req_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       push_0 = 1'b1, push_1 = 1'b1, gnt_0 = 1'b1, gnt_1 = 1'b1;
    logic       req_0, req_1, beat_0, beat_1, done_0, done_1, ovf_0, ovf_1;
    logic [2:0] pend_0, pend_1;

    int n_assert = 0;
    int n_fail   = 0;

    arb_req_ctrl #(.BURST_LEN(4), .CNT_W(3)) dut (
        .clock (clock), .reset (reset),
        .push_0(push_0), .push_1(push_1), .gnt_0(gnt_0), .gnt_1(gnt_1),
        .req_0 (req_0),  .req_1 (req_1),  .beat_0(beat_0), .beat_1(beat_1),
        .done_0(done_0), .done_1(done_1), .pend_0(pend_0), .pend_1(pend_1),
        .ovf_0 (ovf_0),  .ovf_1 (ovf_1)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [5:0] stall_pat;
        stall_pat = 6'b110011;

        // 1: reset held with pushes and grants active
        for (int i = 0; i < 3; i++) begin
            nxt();
            #1;
            chk("rst_out0", {req_0, beat_0, done_0, ovf_0, pend_0}, 32'h0);
            chk("rst_out1", {req_1, beat_1, done_1, ovf_1, pend_1}, 32'h0);
        end
        reset = 1'b0; push_0 = 1'b0; push_1 = 1'b0; gnt_0 = 1'b0; gnt_1 = 1'b0;
        #1;
        chk("rst_pend0", pend_0, 0);
        chk("rst_pend1", pend_1, 0);
        nxt();

        // 2: single transaction on channel 0
        push_0 = 1'b1; #1;
        chk("t2_req_t0", req_0, 0);
        nxt();
        push_0 = 1'b0; #1;
        chk("t2_pend_t1", pend_0, 1);
        chk("t2_req_t1", req_0, 0);
        nxt();
        gnt_0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_req_burst", req_0, 1);
            chk("t2_beat", beat_0, 1);
            chk("t2_done_burst", done_0, 0);
            nxt();
        end
        #1;
        chk("t2_done", done_0, 1);
        chk("t2_req_rel", req_0, 0);
        chk("t2_beat_rel", beat_0, 0);
        chk("t2_pend_end", pend_0, 0);
        nxt();
        gnt_0 = 1'b0; #1;
        chk("t2_done_once", done_0, 0);
        chk("t2_req_idle", req_0, 0);
        nxt();

        // 3: stalled burst, grant pattern 1,1,0,0,1,1
        push_0 = 1'b1; nxt();
        push_0 = 1'b0; nxt();
        for (int i = 0; i < 6; i++) begin
            gnt_0 = stall_pat[5-i];
            #1;
            chk("t3_req", req_0, 1);
            chk("t3_beat", beat_0, {31'b0, stall_pat[5-i]});
            chk("t3_no_done", done_0, 0);
            nxt();
        end
        gnt_0 = 1'b0; #1;
        chk("t3_done", done_0, 1);
        chk("t3_req_rel", req_0, 0);
        chk("t3_pend", pend_0, 0);
        nxt();
        #1;
        chk("t3_done_once", done_0, 0);

        // 4: three back-to-back pushes on channel 1
        push_1 = 1'b1; nxt();
        nxt();
        #1;
        chk("t4_req_early", req_1, 1);
        nxt();
        push_1 = 1'b0; gnt_1 = 1'b1; #1;
        chk("t4_pend3", pend_1, 3);
        for (int i = 0; i < 16; i++) begin
            logic e_req, e_done;
            int   e_pend;
            e_done = (i == 4) || (i == 9) || (i == 14);
            e_req  = !(e_done || i == 15);
            e_pend = (i < 4) ? 3 : (i < 9) ? 2 : (i < 14) ? 1 : 0;
            if (i > 0) #1;
            chk("t4_req", req_1, {31'b0, e_req});
            chk("t4_beat", beat_1, {31'b0, e_req});
            chk("t4_done", done_1, {31'b0, e_done});
            chk("t4_pend", pend_1, e_pend);
            nxt();
        end
        gnt_1 = 1'b0;

        // 5: saturation with no grants, 9 pushes
        push_0 = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            nxt();
            #1;
            chk("t5_pend", pend_0, (k > 7) ? 7 : k);
            chk("t5_ovf", ovf_0, (k >= 8) ? 1 : 0);
        end
        push_0 = 1'b0;
        reset  = 1'b1; nxt();
        reset  = 1'b0; #1;
        chk("t5_rst_clr", {ovf_0, pend_0}, 0);
        push_0 = 1'b1;
        repeat (7) nxt();
        push_0 = 1'b0; #1;
        chk("t5_pend7", pend_0, 7);
        chk("t5_req_held", req_0, 1);
        gnt_0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_0 = (i == 3);
            #1;
            chk("t5_beat", beat_0, 1);
            nxt();
        end
        gnt_0 = 1'b0; push_0 = 1'b0; #1;
        chk("t5_coinc_done", done_0, 1);
        chk("t5_coinc_pend", pend_0, 7);
        chk("t5_coinc_ovf", ovf_0, 0);
        nxt();

        // 6: spurious grant in IDLE, then reset mid-burst on channel 1
        reset = 1'b1; nxt();
        reset = 1'b0; gnt_1 = 1'b1; #1;
        chk("t6_spur_beat", beat_1, 0);
        nxt();
        #1;
        chk("t6_spur_beat2", beat_1, 0);
        chk("t6_spur_req", req_1, 0);
        chk("t6_spur_pend", pend_1, 0);
        gnt_1 = 1'b0; push_1 = 1'b1; nxt();
        push_1 = 1'b0; nxt();
        gnt_1 = 1'b1; #1;
        chk("t6_beat1", beat_1, 1);
        nxt();
        #1;
        chk("t6_beat2", beat_1, 1);
        nxt();
        reset = 1'b1; gnt_1 = 1'b0; nxt();
        #1;
        chk("t6_rst_req", req_1, 0);
        chk("t6_rst_pend", pend_1, 0);
        chk("t6_rst_done", done_1, 0);
        reset = 1'b0; gnt_1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            nxt();
            #1;
            chk("t6_no_done", done_1, 0);
            chk("t6_no_req", req_1, 0);
        end
        gnt_1 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
